// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and width default for the piso / sequence detector pair
package piso_pkg;

  // Default word width, shared with the downstream sequence detector.
  localparam int DEFAULT_WIDTH = 16;

  // Converter state: capture the word, stream it out, then sit terminally.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_t;

  // Bit counter width able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso.sv
// rtl/piso.sv - parallel-in serial-out converter, MSB first, sticky Done
module piso
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Data_in,
  output logic             Serial_Out,
  output logic             Done
);

  localparam int CW = cnt_width(WIDTH);

  // Counter value on the edge that emits the last (LSB) bit.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  piso_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  // FSM, shift register, bit counter and registered outputs in one process;
  // DONE is terminal so only reset can start another word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      shreg      <= '0;
      cnt        <= '0;
      Serial_Out <= 1'b0;
      Done       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // Data_in is sampled here and nowhere else.
          shreg      <= Data_in;
          cnt        <= '0;
          Serial_Out <= 1'b0;
          state      <= SHIFT;
        end
        SHIFT: begin
          Serial_Out <= shreg[WIDTH-1];
          shreg      <= {shreg[WIDTH-2:0], 1'b0};
          cnt        <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end
        end
        DONE: begin
          // First edge here raises Done; later edges rewrite the same values.
          Serial_Out <= 1'b0;
          Done       <= 1'b1;
        end
        default: begin
          state      <= LOAD;
          Serial_Out <= 1'b0;
          Done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso.sv
// tb/tb_piso.sv - self-checking bench for piso against an edge-indexed stream model
module tb_piso;
  import piso_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         serial_out;
  logic         done;

  int total = 0;
  int bad   = 0;

  piso #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Data_in    (data_in),
    .Serial_Out (serial_out),
    .Done       (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           change_at;
    logic [W-1:0] new_data;
    int           cycles;
  } vec_t;

  // Expected outputs after the nth posedge since reset release.
  task automatic model(input logic [W-1:0] word, input int n,
                       output logic so, output logic dn);
    so = 1'b0;
    dn = 1'b0;
    if (n >= 2 && n <= W + 1) so = word[W + 1 - n];
    if (n >= W + 2) dn = 1'b1;
  endtask

  task automatic check(input string name, input int n,
                       input logic exp_so, input logic exp_dn);
    total++;
    if (serial_out !== exp_so || done !== exp_dn) begin
      bad++;
      $display("FAIL %s edge=%0d got so=%b done=%b want so=%b done=%b",
               name, n, serial_out, done, exp_so, exp_dn);
    end
  endtask

  // Expects rst_n low on entry; releases it away from the edge and checks each edge.
  task automatic run_word(input string name, input logic [W-1:0] word,
                          input int change_at, input logic [W-1:0] new_data,
                          input int cycles);
    logic so, dn;
    data_in = word;
    @(negedge clk);
    check({name, "_rst"}, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int n = 1; n <= cycles; n++) begin
      @(posedge clk);
      #1;
      model(word, n, so, dn);
      check(name, n, so, dn);
      if (n == change_at) data_in = new_data;
    end
  endtask

  // Assert reset between edges and confirm outputs clear before the next edge.
  task automatic async_reset(input string name);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check(name, -1, 1'b0, 1'b0);
    #34;
  endtask

  vec_t vecs[$];

  initial begin
    rst_n   = 1'b0;
    data_in = '0;
    #25;

    vecs.push_back('{data: 16'hF000, change_at: 0, new_data: 16'h0000, cycles: W + 4});
    vecs.push_back('{data: 16'hFF11, change_at: 0, new_data: 16'h0000, cycles: W + 4});
    vecs.push_back('{data: 16'hA5A5, change_at: 5, new_data: 16'h0000, cycles: W + 4});
    vecs.push_back('{data: 16'h8001, change_at: W + 3, new_data: 16'h7FFE, cycles: W + 42});
    vecs.push_back('{data: 16'h0001, change_at: 1, new_data: 16'hFFFF, cycles: W + 3});
    for (int i = 0; i < 6; i++) begin
      vecs.push_back('{data: W'($urandom), change_at: int'($urandom_range(1, W + 2)),
                       new_data: W'($urandom), cycles: W + 3});
    end

    foreach (vecs[i]) begin
      run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].change_at,
               vecs[i].new_data, vecs[i].cycles);
      async_reset($sformatf("vec%0d_async", i));
    end

    // Abort at edge 9 of an all-ones word, then a fresh full word.
    run_word("abort_part", 16'hFFFF, 0, 16'h0000, 9);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_clear", 9, 1'b0, 1'b0);
    #35;
    run_word("abort_full", 16'hFFFF, 0, 16'h0000, W + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
